// File: rtl/plcp_signal_serializer.sv
// -----------------------------------------------------------------------------
// plcp_signal_serializer
//
// Accepts a (RATE, LENGTH) request over a valid/ready handshake, builds the
// 24-bit 802.11a SIGNAL word and streams it MSB-first, OUT_W bits per beat,
// with backpressure. Also reports N_DBPS for the latched rate and flags
// unsupported rates (which fall back to DEF_RATE_BITS / 144 bits).
//
// Optional feature macro: PLCP_SERVICE_FIELD_EN
//   defined   -> 16 zero SERVICE bits follow SIGNAL (40-bit frame)
//   undefined -> only the 24 SIGNAL bits are sent
//
// Parameters:
//   OUT_W         bits per output beat (1, 2, 4 or 8)
//   DEF_RATE_BITS RATE code used for unsupported rates
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    request valid          in_ready   block can accept a request
//   rate        rate in Mb/s           length     PSDU length in octets
//   out_valid   out_data valid         out_ready  downstream accepts beat
//   out_data    serial bits, MSB first out_last   final beat of the header
//   n_dbps      data bits per symbol   rate_err   latched rate unsupported
// -----------------------------------------------------------------------------
module plcp_signal_serializer #(
   parameter int         OUT_W         = 1,
   parameter logic [3:0] DEF_RATE_BITS = 4'b1011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       rate,
   input  logic [11:0]      length,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic [7:0]       n_dbps,
   output logic             rate_err
);

`ifdef PLCP_SERVICE_FIELD_EN
   localparam int FRAME_W = 40;
`else
   localparam int FRAME_W = 24;
`endif
   localparam int NB    = FRAME_W / OUT_W;
   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NB - 1);
   localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(NB - 2);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   generate
      if (!(OUT_W == 1 || OUT_W == 2 || OUT_W == 4 || OUT_W == 8)) begin : g_bad_out_w
         $error("plcp_signal_serializer: OUT_W must be 1, 2, 4 or 8");
      end
   endgenerate

   // Rate lookup: {R1..R4, N_DBPS, unsupported flag}
   function automatic logic [12:0] rate_map(input logic [7:0] r);
      logic [12:0] m;
      case (r)
         8'd6:    m = {4'b1101, 8'd24,  1'b0};
         8'd9:    m = {4'b1111, 8'd36,  1'b0};
         8'd12:   m = {4'b0101, 8'd48,  1'b0};
         8'd18:   m = {4'b0111, 8'd72,  1'b0};
         8'd24:   m = {4'b1001, 8'd96,  1'b0};
         8'd36:   m = {4'b1011, 8'd144, 1'b0};
         8'd48:   m = {4'b0001, 8'd192, 1'b0};
         8'd54:   m = {4'b0011, 8'd216, 1'b0};
         default: m = {DEF_RATE_BITS, 8'd144, 1'b1};
      endcase
      return m;
   endfunction

   // Even parity over SIGNAL bits 23..7
   function automatic logic even_parity(input logic [16:0] v);
      return ^v;
   endfunction

   logic [12:0]        map_s;
   logic [16:0]        head_s;
   logic [23:0]        signal_s;
   logic [FRAME_W-1:0] frame_s;

   logic [0:0]         state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [FRAME_W-1:0] shreg_q,     shreg_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q,  out_data_d;
   logic               out_last_q,  out_last_d;
   logic               in_ready_q,  in_ready_d;
   logic [7:0]         n_dbps_q,    n_dbps_d;
   logic               rate_err_q,  rate_err_d;

   // Assemble the SIGNAL word for the request on the inputs; LENGTH goes out LSB first
   always_comb begin
      map_s  = rate_map(rate);
      head_s = {map_s[12:9], 1'b0, 12'h000};
      for (int i = 0; i < 12; i++) begin
         head_s[11 - i] = length[i];
      end
      signal_s = {head_s, even_parity(head_s), 6'b000000};
   end

`ifdef PLCP_SERVICE_FIELD_EN
   assign frame_s = {signal_s, 16'h0000};
`else
   assign frame_s = signal_s;
`endif

   // Next-state logic: the shift register keeps the not-yet-sent bits at its top
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      in_ready_d  = in_ready_q;
      n_dbps_d    = n_dbps_q;
      rate_err_d  = rate_err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d     = S_SEND;
               cnt_d       = {CNT_W{1'b0}};
               shreg_d     = frame_s << OUT_W;
               out_data_d  = frame_s[FRAME_W-1 -: OUT_W];
               out_last_d  = 1'b0;
               out_valid_d = 1'b1;
               in_ready_d  = 1'b0;
               n_dbps_d    = map_s[8:1];
               rate_err_d  = map_s[0];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (cnt_q == CNT_LAST) begin
                  state_d     = S_IDLE;
                  cnt_d       = {CNT_W{1'b0}};
                  out_valid_d = 1'b0;
                  out_data_d  = {OUT_W{1'b0}};
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
               end else begin
                  cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  shreg_d    = shreg_q << OUT_W;
                  out_data_d = shreg_q[FRAME_W-1 -: OUT_W];
                  out_last_d = (cnt_q == CNT_PENULT);
               end
            end else begin
               state_d = S_SEND;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cnt_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
            out_data_d  = {OUT_W{1'b0}};
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         shreg_q     <= {FRAME_W{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {OUT_W{1'b0}};
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         n_dbps_q    <= 8'd0;
         rate_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         in_ready_q  <= in_ready_d;
         n_dbps_q    <= n_dbps_d;
         rate_err_q  <= rate_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign n_dbps    = n_dbps_q;
   assign rate_err  = rate_err_q;

endmodule

// File: tb/tb_plcp_signal_serializer.sv
// -----------------------------------------------------------------------------
// tb_plcp_signal_serializer
//
// Four serializers (OUT_W = 1, 2, 4, 8) share clock, reset, request and
// out_ready. Every accepted request pushes the expected beats into a per-
// instance queue; each beat the DUT hands over is popped and compared.
// Honours PLCP_SERVICE_FIELD_EN to match the design build.
// -----------------------------------------------------------------------------
module tb_plcp_signal_serializer;

`ifdef PLCP_SERVICE_FIELD_EN
   localparam int FRAME_W = 40;
`else
   localparam int FRAME_W = 24;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  rate;
   logic [11:0] length;
   logic        out_ready;
   logic        chk_rst = 1'b0;
   logic        chk_b2b = 1'b0;
   logic        chk_end = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   // Cycle counter for the back-to-back gap measurement
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model: {rate_err, n_dbps, SIGNAL[23:0]}
   function automatic logic [32:0] model_signal(input logic [7:0] r, input logic [11:0] len);
      logic [3:0]  code;
      logic [7:0]  nd;
      logic        err;
      logic [16:0] head;
      err = 1'b0;
      case (r)
         8'd6:    begin code = 4'b1101; nd = 8'd24;  end
         8'd9:    begin code = 4'b1111; nd = 8'd36;  end
         8'd12:   begin code = 4'b0101; nd = 8'd48;  end
         8'd18:   begin code = 4'b0111; nd = 8'd72;  end
         8'd24:   begin code = 4'b1001; nd = 8'd96;  end
         8'd36:   begin code = 4'b1011; nd = 8'd144; end
         8'd48:   begin code = 4'b0001; nd = 8'd192; end
         8'd54:   begin code = 4'b0011; nd = 8'd216; end
         default: begin code = 4'b1011; nd = 8'd144; err = 1'b1; end
      endcase
      head = {code, 1'b0, 12'h000};
      for (int i = 0; i < 12; i++) head[11 - i] = len[i];
      return {err, nd, head, ^head, 6'b000000};
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_w
      localparam int W  = 1 << gi;
      localparam int NB = FRAME_W / W;

      logic         rdy;
      logic         ov;
      logic         ol;
      logic         rerr;
      logic [W-1:0] od;
      logic [7:0]   nd;
      logic [17:0]  exp_q[$];      // {rate_err, n_dbps, last, data}
      logic         stall_prev = 1'b0;
      logic [W-1:0] held_d;
      logic         held_l;
      logic         have_last = 1'b0;
      logic         last_in_b2b = 1'b0;
      int           last_cyc = 0;

      plcp_signal_serializer #(.OUT_W(W)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (rdy),
         .rate      (rate),
         .length    (length),
         .out_valid (ov),
         .out_ready (out_ready),
         .out_data  (od),
         .out_last  (ol),
         .n_dbps    (nd),
         .rate_err  (rerr)
      );

      // Scoreboard push on every accepted request, plus back-to-back gap check
      always @(posedge clk) begin
         if (!rst && in_valid && rdy) begin
            logic [32:0]        m;
            logic [FRAME_W-1:0] f;
            logic [FRAME_W-1:0] t;
            m = model_signal(rate, length);
            f = '0;
            f[FRAME_W-1 -: 24] = m[23:0];
            for (int k = 0; k < NB; k++) begin
               t = f << (k * W);
               exp_q.push_back({m[32], m[31:24], (k == NB - 1), 8'(t[FRAME_W-1 -: W])});
            end
            if (chk_b2b && have_last && last_in_b2b)
               check_val($sformatf("w%0d_b2b_gap", W), 32'(cyc - last_cyc), 32'd1);
            have_last <= 1'b0;
         end
         if (!rst && ov && out_ready && ol) begin
            have_last   <= 1'b1;
            last_in_b2b <= chk_b2b;
            last_cyc    <= cyc;
         end
      end

      // A reset discards any frame in flight
      always @(posedge rst) exp_q.delete();

      // Output monitor, sampled on the falling edge
      always @(negedge clk) begin
         if (chk_rst) begin
            check_val($sformatf("w%0d_rst_in_ready", W), 32'(rdy), 32'd1);
            check_val($sformatf("w%0d_rst_out_valid", W), 32'(ov), 32'd0);
            check_val($sformatf("w%0d_rst_out_data", W), 32'(od), 32'd0);
            check_val($sformatf("w%0d_rst_out_last", W), 32'(ol), 32'd0);
            check_val($sformatf("w%0d_rst_n_dbps", W), 32'(nd), 32'd0);
            check_val($sformatf("w%0d_rst_rate_err", W), 32'(rerr), 32'd0);
         end
         if (rst) begin
            stall_prev <= 1'b0;
         end else begin
            check_val($sformatf("w%0d_in_ready_vs_valid", W), 32'(rdy), 32'(!ov));
            if (stall_prev) begin
               check_val($sformatf("w%0d_stall_valid", W), 32'(ov), 32'd1);
               check_val($sformatf("w%0d_stall_data", W), 32'(od), 32'(held_d));
               check_val($sformatf("w%0d_stall_last", W), 32'(ol), 32'(held_l));
            end
            if (ov && out_ready) begin
               if (exp_q.size() == 0) begin
                  check_val($sformatf("w%0d_unexpected_beat", W), 32'd1, 32'd0);
               end else begin
                  logic [17:0] e;
                  e = exp_q.pop_front();
                  check_val($sformatf("w%0d_data", W), 32'(od), 32'(e[7:0]));
                  check_val($sformatf("w%0d_last", W), 32'(ol), 32'(e[8]));
                  check_val($sformatf("w%0d_n_dbps", W), 32'(nd), 32'(e[16:9]));
                  check_val($sformatf("w%0d_rate_err", W), 32'(rerr), 32'(e[17]));
               end
            end
            stall_prev <= ov && !out_ready;
            held_d     <= od;
            held_l     <= ol;
         end
         if (chk_end) check_val($sformatf("w%0d_leftover_beats", W), 32'(exp_q.size()), 32'd0);
      end
   end

   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      while (!(g_w[0].rdy && g_w[1].rdy && g_w[2].rdy && g_w[3].rdy) && n < 500) begin
         @(posedge clk);
         #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (n >= 500) check_val("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input logic [7:0] r, input logic [11:0] l, input bit rnd);
      wait_idle(rnd);
      rate     = r;
      length   = l;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
   endtask

   logic [7:0] rate_tbl [11] = '{8'd6, 8'd9, 8'd12, 8'd18, 8'd24, 8'd36,
                                 8'd48, 8'd54, 8'd7, 8'd0, 8'd100};

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      rate      = 8'd0;
      length    = 12'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_rst = 1'b1;
      @(negedge clk);
      #1 chk_rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed requests with out_ready held high
      out_ready = 1'b1;
      send(8'd6,  12'd100,  1'b0);
      send(8'd12, 12'd1,    1'b0);
      send(8'd54, 12'd4095, 1'b0);
      send(8'd7,  12'd100,  1'b0);
      send(8'd48, 12'd0,    1'b0);
      send(8'd9,  12'h800,  1'b0);
      send(8'd18, 12'h5A5,  1'b0);
      send(8'd24, 12'h3C3,  1'b0);
      send(8'd36, 12'd1500, 1'b0);
      send(8'd255, 12'd77,  1'b0);
      wait_idle(1'b0);

      // in_valid held high with out_ready toggling every cycle
      rate     = 8'd18;
      length   = 12'hABC;
      chk_b2b  = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 150; c++) begin
         @(posedge clk);
         #1 out_ready = ~out_ready;
      end
      in_valid  = 1'b0;
      chk_b2b   = 1'b0;
      out_ready = 1'b1;
      wait_idle(1'b0);

      // Random rates, lengths and backpressure
      for (int j = 0; j < 25; j++) begin
         send(rate_tbl[$urandom_range(0, 10)], 12'($urandom), 1'b1);
      end
      out_ready = 1'b1;
      wait_idle(1'b0);

      // Reset on the second beat of a frame
      send(8'd24, 12'd300, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("rst_async_out_valid", 32'(g_w[3].ov), 32'd0);
      check_val("rst_async_in_ready", 32'(g_w[3].rdy), 32'd1);
      check_val("rst_async_out_valid_w1", 32'(g_w[0].ov), 32'd0);
      chk_rst = 1'b1;
      @(negedge clk);
      #1 chk_rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      send(8'd36, 12'd55, 1'b0);
      wait_idle(1'b0);
      repeat (2) @(posedge clk);

      #1 chk_end = 1'b1;
      @(negedge clk);
      #1 chk_end = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/plcp_signal_serializer.md
Name: plcp_signal_serializer

Overview:
Sequential successor to the combinational SIGNAL-field encoder. It accepts a (RATE, LENGTH) request over a valid/ready handshake and builds the 24-bit 802.11a SIGNAL word: RATE bits, reserved bit, bit-reversed LENGTH, even parity and 6 tail zeros. It then streams the word out OUT_W bits per beat, with backpressure, to the convolutional-encoder front end. It also reports the rate's N_DBPS for the DATA-field path and flags unsupported rates.

Parameters:
OUT_W, 1, bits per output beat; legal values 1, 2, 4, 8; any other value is a configuration error.
DEF_RATE_BITS, 4'b1011, RATE code used for unsupported RATE values (36 Mb/s).

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
rate  input  8  rate in Mb/s (6, 9, 12, 18, 24, 36, 48, 54)
length  input  12  PSDU length in octets
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts beat
out_data  output  OUT_W  serial bits; MSB is transmitted first
out_last  output  1  final beat of the header
n_dbps  output  8  data bits per OFDM symbol for the latched rate
rate_err  output  1  latched rate was unsupported

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0; out_data=0; out_last=0; n_dbps=0; rate_err=0; beat counter=0. Takes effect immediately, including mid-frame. No partial frame resumes after reset.
- Rate map (code R1..R4, N_DBPS):
  - 6: 1101, 24
  - 9: 1111, 36
  - 12: 0101, 48
  - 18: 0111, 72
  - 24: 1001, 96
  - 36: 1011, 144
  - 48: 0001, 192
  - 54: 0011, 216
  - Other: DEF_RATE_BITS, 144, rate_err=1.
- SIGNAL[23:0] = {R1..R4, 1'b0, LENGTH[0]..LENGTH[11], P, 6'b0}. P is the XOR of bits 23..7 (even parity). SIGNAL[23] is transmitted first.
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches SIGNAL, n_dbps and rate_err; go to SEND.
  - SEND: in_ready=0; out_valid=1. Beat k carries SIGNAL[23-k*OUT_W -: OUT_W]. The counter advances only on out_valid & out_ready. out_data and out_last hold stable while stalled.
  - out_last=1 on beat NB-1, where NB = 24/OUT_W (or 40/OUT_W with the optional feature). Acceptance of the last beat returns to IDLE: out_valid=0 and in_ready=1 on the following cycle.
- Latency: the first beat is valid the cycle after the accepting edge. With out_ready held high, a frame occupies NB cycles. Back-to-back frames have one IDLE cycle between them.
- n_dbps and rate_err hold their values until the next accepted request.
- in_valid in SEND is ignored; the request waits upstream.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
Macro PLCP_SERVICE_FIELD_EN.
- Defined: after the 24 SIGNAL bits, the block appends the 16-bit SERVICE field, all zeros (the scrambler-init bits are zero pre-scrambling). NB = 40/OUT_W, and out_last marks the final SERVICE beat.
- Undefined: only SIGNAL is sent; NB = 24/OUT_W.

Test Plan:
1. OUT_W=8, rate=6, length=100, out_ready=1 -> beats 0xD1, 0x30, 0x00; out_last on the 3rd beat; n_dbps=24; rate_err=0.
2. OUT_W=1, rate=12, length=1 -> 24-bit serial stream equals 0x540040 MSB-first (parity=1); out_last on beat 24.
3. OUT_W=4, rate=54, length=4095 -> nibbles 3,7,F,F,8,0; n_dbps=216.
4. OUT_W=8, rate=7, length=100 -> rate_err=1; beats 0xB1, 0x30, 0x00; n_dbps=144.
5. OUT_W=2, out_ready toggled 1/0 every cycle, in_valid held high -> out_data stable during stalls; in_ready stays 0 until the last beat is accepted; the second request is accepted exactly one cycle later.
6. Assert rst on the 2nd beat of a frame -> out_valid=0 and in_ready=1 immediately. A new request after release produces a complete fresh frame. With PLCP_SERVICE_FIELD_EN, also check 16 trailing zero bits and out_last on beat 40/OUT_W.
